// File: rtl/pic_control_logic.sv
// pic_control_logic: 8259A command registers, IRR/ISR fixed-priority tracking and two-pulse INTA sequencer
module pic_control_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] D,
  input  logic [3:0] ICW,
  input  logic [2:0] OCW,
  input  logic [7:0] IR,
  input  logic       INTA_n,
  output logic       INT,
  output logic [7:0] IRR,
  output logic [7:0] ISR,
  output logic [7:0] IMR,
  output logic [1:0] Read_command,
  output logic [7:0] Interrupt_Vector,
  output logic       IV_ready,
  output logic       init_done
);
  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;
  state_t     r_state;
  logic [3:0] r_icw_q;
  logic [2:0] r_ocw_q;
  logic [7:0] r_ir_q;
  logic [4:0] r_t;
  logic [2:0] r_lvl;
  logic       r_ltim, r_sngl, r_ic4, r_aeoi, r_spur;
  logic [3:0] w_icw;
  logic [2:0] w_ocw;
  logic [7:0] w_pend, w_irr_n, w_isr_n;
  logic [2:0] w_hp, w_isr_lo;
  logic       w_pvalid, w_ack1, w_ack2_exit, w_eoi_ns, w_eoi_s;
  assign w_icw       = ICW & ~r_icw_q;
  assign w_ocw       = OCW & ~r_ocw_q;
  assign w_pend      = IRR & ~IMR;
  assign w_pvalid    = |w_pend;
  assign w_ack1      = r_state == IDLE && !INTA_n;
  assign w_ack2_exit = r_state == ACK2 && INTA_n;
  assign w_eoi_ns    = w_ocw[1] && D[7:5] == 3'b001;
  assign w_eoi_s     = w_ocw[1] && D[7:5] == 3'b011;
  // lowest set index wins; both default to 7 when empty
  always_comb begin
    w_hp = 3'd7;
    w_isr_lo = 3'd7;
    for (int i = 7; i >= 0; i--) begin
      if (w_pend[i]) w_hp = 3'(i);
      if (ISR[i]) w_isr_lo = 3'(i);
    end
  end
  // ordering encodes precedence: ack clear beats a new IR edge, ACK1 set beats any EOI clear
  always_comb begin
    w_irr_n = r_ltim ? IR : (IRR | (IR & ~r_ir_q));
    if (w_ack1 && w_pvalid) w_irr_n[w_hp] = 1'b0;
    w_isr_n = ISR;
    if (w_eoi_ns && |ISR) w_isr_n[w_isr_lo] = 1'b0;
    if (w_eoi_s) w_isr_n[D[2:0]] = 1'b0;
    if (w_ack2_exit && r_aeoi && !r_spur) w_isr_n[r_lvl] = 1'b0;
    if (w_ack1 && w_pvalid) w_isr_n[w_hp] = 1'b1;
  end
  // the ICW3 cascade byte has no consumer in a single-chip model; only its init_done effect is kept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_icw_q <= '0;
      r_ocw_q <= '0;
      r_ir_q <= '0;
      r_t <= '0;
      r_lvl <= '0;
      r_ltim <= 1'b0;
      r_sngl <= 1'b0;
      r_ic4 <= 1'b0;
      r_aeoi <= 1'b0;
      r_spur <= 1'b0;
      INT <= 1'b0;
      IRR <= '0;
      ISR <= '0;
      IMR <= '0;
      Read_command <= 2'b10;
      Interrupt_Vector <= '0;
      IV_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      r_icw_q <= ICW;
      r_ocw_q <= OCW;
      r_ir_q <= IR;
      IRR <= w_irr_n;
      ISR <= w_isr_n;
      INT <= init_done && w_pvalid && (~|ISR || w_hp < w_isr_lo) && r_state == IDLE;
      case (r_state)
        IDLE: if (!INTA_n) begin
          r_state <= ACK1;
          r_lvl <= w_hp;
          r_spur <= !w_pvalid;
        end
        ACK1: if (INTA_n) r_state <= WAIT2;
        WAIT2: if (!INTA_n) begin
          r_state <= ACK2;
          Interrupt_Vector <= {r_t, r_lvl};
          IV_ready <= 1'b1;
        end
        ACK2: if (INTA_n) begin
          r_state <= IDLE;
          IV_ready <= 1'b0;
        end
      endcase
      if (w_icw[1]) begin
        r_t <= D[7:3];
        if (r_sngl && !r_ic4) init_done <= 1'b1;
      end
      if (w_icw[2] && !r_ic4) init_done <= 1'b1;
      if (w_icw[3]) begin
        r_aeoi <= D[1];
        init_done <= 1'b1;
      end
      if (w_ocw[0]) IMR <= D;
      if (w_ocw[2] && D[1]) Read_command <= {1'b1, D[0]};
      if (w_icw[0]) begin
        IMR <= '0;
        ISR <= '0;
        IRR <= '0;
        r_ltim <= D[3];
        r_sngl <= D[1];
        r_ic4 <= D[0];
        r_aeoi <= 1'b0;
        Read_command <= 2'b10;
        init_done <= 1'b0;
        r_state <= IDLE;
        IV_ready <= 1'b0;
      end
    end
  end
endmodule
